// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite types, transfer constants and the responder FSM encoding
// used by the wait-state SRAM subordinate and its lane-mask helper.
package ahb_sram_pkg;

    typedef logic [1:0] htrans_t;
    typedef logic [2:0] hsize_t;

    localparam htrans_t HTRANS_IDLE   = 2'b00;
    localparam htrans_t HTRANS_BUSY   = 2'b01;
    localparam htrans_t HTRANS_NONSEQ = 2'b10;
    localparam htrans_t HTRANS_SEQ    = 2'b11;

    localparam hsize_t HSIZE_BYTE  = 3'd0;
    localparam hsize_t HSIZE_HALF  = 3'd1;
    localparam hsize_t HSIZE_WORD  = 3'd2;
    localparam hsize_t HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        OKAY,
        ERR1,
        ERR2
    } state_t;

    function automatic logic is_active(input htrans_t trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_sram_lane_mask.sv
// Byte-lane enable generator: lanes covered by an aligned transfer of the
// given HSIZE starting at the given in-word byte offset.
module ahb_sram_lane_mask
    import ahb_sram_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  hsize_t                           hsize,
    input  logic [$clog2(DataWidth/8)-1:0]   addr_lo,
    output logic [DataWidth/8-1:0]           mask
);

    localparam int Lanes = DataWidth / 8;

    // A lane is enabled when it lies in the same size-aligned block as the address.
    always_comb begin
        mask = '0;
        for (int i = 0; i < Lanes; i++) begin
            mask[i] = ((i >> hsize) == (int'(addr_lo) >> hsize));
        end
    end

endmodule

// File: rtl/ahb_sram_ws.sv
// AHB-Lite SRAM subordinate with a fixed number of wait states per OKAY data
// phase and a two-cycle ERROR response for out-of-range or illegal transfers.
module ahb_sram_ws
    import ahb_sram_pkg::*;
#(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32,
    parameter int Depth        = 1024,
    parameter int WaitStates   = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [AddressWidth-1:0] HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [DataWidth-1:0]    HWDATA,
    input  logic                    HREADY,
    output logic [DataWidth-1:0]    HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP
);

    localparam int         Lanes    = DataWidth / 8;
    localparam int         LaneBits = $clog2(Lanes);
    localparam int         IdxBits  = $clog2(Depth);
    localparam logic [63:0] MemBytes = 64'(Depth) * 64'(Lanes);
    localparam logic [3:0]  WaitLoad = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;

    if (DataWidth != 32 && DataWidth != 64) begin : g_bad_data_width
        $error("ahb_sram_ws: DataWidth must be 32 or 64");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("ahb_sram_ws: Depth must be a power of two");
    end
    if (WaitStates < 0 || WaitStates > 15) begin : g_bad_wait_states
        $error("ahb_sram_ws: WaitStates must be in 0..15");
    end

    state_t                 state, next_state;
    logic [3:0]             wait_cnt;
    logic                   d_write;
    hsize_t                 d_size;
    logic [LaneBits-1:0]    d_lane;
    logic [IdxBits-1:0]     d_idx;
    logic [DataWidth-1:0]   mem [Depth];

    logic [63:0]            haddr_ext;
    logic                   addr_err;
    logic                   accept;
    logic [Lanes-1:0]       wr_mask;
    logic                   wr_en;
    logic                   rd_write;
    logic [IdxBits-1:0]     rd_idx;
    logic                   load_rd;
    logic [DataWidth-1:0]   rd_word;
    logic                   unused_hburst;

    assign unused_hburst = ^HBURST;

    assign haddr_ext = 64'(HADDR);
    assign addr_err  = (haddr_ext >= MemBytes)
                     || ((32'd8 << HSIZE) > 32'(DataWidth))
                     || ((haddr_ext & ((64'd1 << HSIZE) - 64'd1)) != 64'd0);
    assign accept    = HSEL && HREADY && HREADYOUT && is_active(HTRANS);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, OKAY, ERR2: begin
                if (!accept) begin
                    next_state = IDLE;
                end else if (addr_err) begin
                    next_state = ERR1;
                end else if (WaitStates == 0) begin
                    next_state = OKAY;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT:    next_state = (wait_cnt == 4'd0) ? OKAY : WAIT;
            ERR1:    next_state = ERR2;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            WAIT: HREADYOUT = 1'b0;
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ERR2:    HRESP = 1'b1;
            default: ;
        endcase
    end

    // The counter is reloaded on every entry into WAIT, including back-to-back phases.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wait_cnt <= 4'd0;
        end else if (state != WAIT && next_state == WAIT) begin
            wait_cnt <= WaitLoad;
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            d_write <= 1'b0;
            d_size  <= HSIZE_BYTE;
            d_lane  <= '0;
            d_idx   <= '0;
        end else if (accept) begin
            d_write <= HWRITE;
            d_size  <= HSIZE;
            d_lane  <= HADDR[LaneBits-1:0];
            d_idx   <= HADDR[LaneBits +: IdxBits];
        end
    end

    ahb_sram_lane_mask #(
        .DataWidth (DataWidth)
    ) u_lane_mask (
        .hsize   (d_size),
        .addr_lo (d_lane),
        .mask    (wr_mask)
    );

    assign wr_en    = (state == OKAY) && d_write;
    assign rd_write = (state == WAIT) ? d_write : HWRITE;
    assign rd_idx   = (state == WAIT) ? d_idx : HADDR[LaneBits +: IdxBits];
    assign load_rd  = (next_state == OKAY) && !rd_write;

    // A read accepted during a write's data phase sees the bytes being written.
    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_en && d_idx == rd_idx) begin
            for (int b = 0; b < Lanes; b++) begin
                if (wr_mask[b]) begin
                    rd_word[8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HRDATA <= '0;
        end else if (load_rd) begin
            HRDATA <= rd_word;
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int b = 0; b < Lanes; b++) begin
                if (wr_mask[b]) begin
                    mem[d_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_ws.sv
// Directed bench for ahb_sram_ws: three instances (0, 3 and 2 wait states)
// sharing one AHB master, driven from a vector table plus corner sequences.
module tb_ahb_sram_ws;

    typedef struct {
        int          dut;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        exp_resp;
        int          exp_low;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    logic        hclk = 1'b0;
    logic        rst;
    logic        rst2;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] rdata0, rdata1, rdata2;
    logic        ro0, ro1, ro2;
    logic        resp0, resp1, resp2;
    logic [31:0] hrdata_m;
    logic        hresp_m;
    int          active;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[$];

    always #5 hclk = ~hclk;

    assign hready   = (active == 0) ? ro0    : (active == 1) ? ro1    : ro2;
    assign hresp_m  = (active == 0) ? resp0  : (active == 1) ? resp1  : resp2;
    assign hrdata_m = (active == 0) ? rdata0 : (active == 1) ? rdata1 : rdata2;

    ahb_sram_ws #(.WaitStates(0)) u_dut0 (
        .HCLK(hclk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rdata0), .HREADYOUT(ro0), .HRESP(resp0)
    );

    ahb_sram_ws #(.WaitStates(3)) u_dut3 (
        .HCLK(hclk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rdata1), .HREADYOUT(ro1), .HRESP(resp1)
    );

    ahb_sram_ws #(.WaitStates(2)) u_dut2 (
        .HCLK(hclk), .HRESET(rst2), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rdata2), .HREADYOUT(ro2), .HRESP(resp2)
    );

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic void addVec(input int dut, input logic wr, input logic [31:0] addr,
                                   input logic [2:0] size, input logic [31:0] wdata,
                                   input logic exp_resp, input int exp_low,
                                   input logic chk_data, input logic [31:0] exp_data);
        vec_t v;
        v.dut = dut; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
        v.exp_resp = exp_resp; v.exp_low = exp_low; v.chk_data = chk_data; v.exp_data = exp_data;
        vecs.push_back(v);
    endfunction

    // One isolated transfer: address phase, data phase with bounded wait, then idle.
    task automatic applyStimulus(input int dut, input logic wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 output logic resp, output int low, output logic [31:0] rdata);
        active    = dut;
        hsel      = 3'b000;
        hsel[dut] = 1'b1;
        htrans    = 2'b10;
        hwrite    = wr;
        haddr     = addr;
        hsize     = size;
        tick();
        htrans = 2'b00;
        hsel   = 3'b000;
        hwdata = wdata;
        low    = 0;
        while (hready == 1'b0 && low < 40) begin
            low++;
            tick();
        end
        resp  = hresp_m;
        rdata = hrdata_m;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        resp;
        int          low;
        logic [31:0] rd;

        rst = 1'b1; rst2 = 1'b1; active = 0;
        hsel = 3'b000; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hwdata = '0;
        #3;
        checkOutput("rst_ready0", {31'd0, ro0}, 32'd1);
        checkOutput("rst_resp0", {31'd0, resp0}, 32'd0);
        checkOutput("rst_rdata0", rdata0, 32'd0);
        checkOutput("rst_ready3", {31'd0, ro1}, 32'd1);
        checkOutput("rst_rdata3", rdata1, 32'd0);
        checkOutput("rst_ready2", {31'd0, ro2}, 32'd1);
        tick();
        tick();
        rst = 1'b0; rst2 = 1'b0;
        tick();

        addVec(0, 1, 32'h10,  3'd2, 32'hDEADBEEF, 0, 0, 0, 32'h0);
        addVec(0, 0, 32'h10,  3'd2, 32'h0,        0, 0, 1, 32'hDEADBEEF);
        addVec(0, 1, 32'h20,  3'd2, 32'h11223344, 0, 0, 0, 32'h0);
        addVec(0, 1, 32'h22,  3'd0, 32'hAAAAAAAA, 0, 0, 0, 32'h0);
        addVec(0, 0, 32'h20,  3'd2, 32'h0,        0, 0, 1, 32'h11AA3344);
        addVec(0, 1, 32'h22,  3'd1, 32'h55667788, 0, 0, 0, 32'h0);
        addVec(0, 0, 32'h20,  3'd2, 32'h0,        0, 0, 1, 32'h55663344);
        addVec(0, 0, 32'h21,  3'd0, 32'h0,        0, 0, 1, 32'h55663344);
        addVec(0, 1, 32'h4,   3'd2, 32'h0BADF00D, 0, 0, 0, 32'h0);
        addVec(0, 1, 32'h0,   3'd2, 32'h01234567, 0, 0, 0, 32'h0);
        addVec(0, 1, 32'h1,   3'd1, 32'hFFFFFFFF, 1, 1, 0, 32'h0);
        addVec(0, 0, 32'h1,   3'd1, 32'h0,        1, 1, 0, 32'h0);
        addVec(0, 0, 32'h0,   3'd2, 32'h0,        0, 0, 1, 32'h01234567);
        addVec(0, 1, 32'h0,   3'd3, 32'hFFFFFFFF, 1, 1, 0, 32'h0);
        addVec(0, 0, 32'h2,   3'd2, 32'h0,        1, 1, 0, 32'h0);
        addVec(0, 0, 32'h0,   3'd2, 32'h0,        0, 0, 1, 32'h01234567);
        addVec(0, 1, 32'hFFC, 3'd2, 32'hCAFEF00D, 0, 0, 0, 32'h0);
        addVec(0, 0, 32'hFFF, 3'd0, 32'h0,        0, 0, 1, 32'hCAFEF00D);
        addVec(0, 1, 32'h1000,3'd2, 32'h12121212, 1, 1, 0, 32'h0);
        addVec(1, 1, 32'h0,   3'd2, 32'h89ABCDEF, 0, 3, 0, 32'h0);
        addVec(1, 0, 32'h0,   3'd2, 32'h0,        0, 3, 1, 32'h89ABCDEF);
        addVec(1, 0, 32'h1000,3'd2, 32'h0,        1, 1, 0, 32'h0);
        addVec(2, 1, 32'h8,   3'd2, 32'h5A5A5A5A, 0, 2, 0, 32'h0);
        addVec(2, 0, 32'h8,   3'd2, 32'h0,        0, 2, 1, 32'h5A5A5A5A);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, resp, low, rd);
            checkOutput($sformatf("v%0d_resp", i), {31'd0, resp}, {31'd0, vecs[i].exp_resp});
            checkOutput($sformatf("v%0d_low", i), 32'(low), 32'(vecs[i].exp_low));
            if (vecs[i].chk_data) begin
                checkOutput($sformatf("v%0d_data", i), rd, vecs[i].exp_data);
            end
        end

        // Out-of-range read followed by a pending NONSEQ accepted in ERR2.
        active = 0; hsel = 3'b001; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h1000;
        tick();
        checkOutput("err1_ready", {31'd0, ro0}, 32'd0);
        checkOutput("err1_resp", {31'd0, resp0}, 32'd1);
        haddr = 32'h4;
        tick();
        checkOutput("err2_ready", {31'd0, ro0}, 32'd1);
        checkOutput("err2_resp", {31'd0, resp0}, 32'd1);
        checkOutput("err2_hold", rdata0, 32'hCAFEF00D);
        tick();
        htrans = 2'b00; hsel = 3'b000;
        checkOutput("b2b_ok_ready", {31'd0, ro0}, 32'd1);
        checkOutput("b2b_ok_resp", {31'd0, resp0}, 32'd0);
        checkOutput("b2b_ok_data", rdata0, 32'h0BADF00D);
        tick();

        // Write immediately followed by a read of the same word.
        hsel = 3'b001; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
        tick();
        checkOutput("raw_wr_ready", {31'd0, ro0}, 32'd1);
        hwdata = 32'h12345678; hwrite = 1'b0;
        tick();
        htrans = 2'b00; hsel = 3'b000;
        checkOutput("raw_rd_ready", {31'd0, ro0}, 32'd1);
        checkOutput("raw_rd_data", rdata0, 32'h12345678);
        tick();
        applyStimulus(0, 1'b0, 32'h30, 3'd2, 32'h0, resp, low, rd);
        checkOutput("raw_mem_data", rd, 32'h12345678);

        // BUSY while selected and NONSEQ while deselected both answer zero-wait OKAY.
        hsel = 3'b001; htrans = 2'b01; haddr = 32'h1000;
        tick();
        checkOutput("busy_ready", {31'd0, ro0}, 32'd1);
        checkOutput("busy_resp", {31'd0, resp0}, 32'd0);
        hsel = 3'b000; htrans = 2'b10;
        tick();
        checkOutput("nosel_ready", {31'd0, ro0}, 32'd1);
        checkOutput("nosel_resp", {31'd0, resp0}, 32'd0);
        htrans = 2'b00;
        tick();

        // Reset pulsed during the second wait cycle of a write must drop it.
        active = 2; hsel = 3'b100; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8; hsize = 3'd2;
        tick();
        htrans = 2'b00; hsel = 3'b000; hwdata = 32'hFFFFFFFF;
        checkOutput("ws_wait1_ready", {31'd0, ro2}, 32'd0);
        tick();
        checkOutput("ws_wait2_ready", {31'd0, ro2}, 32'd0);
        #2 rst2 = 1'b1;
        #1;
        checkOutput("async_rst_ready", {31'd0, ro2}, 32'd1);
        checkOutput("async_rst_resp", {31'd0, resp2}, 32'd0);
        checkOutput("async_rst_rdata", rdata2, 32'd0);
        tick();
        rst2 = 1'b0;
        tick();
        applyStimulus(2, 1'b0, 32'h8, 3'd2, 32'h0, resp, low, rd);
        checkOutput("post_rst_low", 32'(low), 32'd2);
        checkOutput("post_rst_data", rd, 32'h5A5A5A5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_sram_ws.md
AHB_SRAM_WS -- requirements
Module: ahb_sram_ws

Interface
REQ-001 SHALL have parameter AddressWidth, default 32, HADDR width.
REQ-002 SHALL have parameter DataWidth, default 32, HWDATA/HRDATA width; legal values 32 or 64, elaboration error otherwise.
REQ-003 SHALL have parameter Depth, default 1024, memory words; power of two, elaboration error otherwise.
REQ-004 SHALL have parameter WaitStates, default 0, HREADYOUT-low cycles per OKAY data phase; legal range 0..15.
REQ-005 SHALL have these ports:
- HCLK  in  1  sole clock, rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  subordinate select.
- HADDR  in  AddressWidth  byte address.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; ignored, each beat handled independently.
- HWDATA  in  DataWidth  write data, data phase.
- HREADY  in  1  bus ready.
- HRDATA  out  DataWidth  read data.
- HREADYOUT  out  1  subordinate ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-006 SHALL accept an address phase only when HSEL && HREADY && HTRANS is NONSEQ or SEQ; it SHALL register HADDR, HWRITE and HSIZE then.
REQ-007 SHALL answer IDLE/BUSY, or HSEL=0, with a zero-wait OKAY.
REQ-008 SHALL classify an accepted transfer as an error in three cases:
- HADDR >= Depth*DataWidth/8.
- 8<<HSIZE > DataWidth.
- HADDR not aligned to 1<<HSIZE.
REQ-009 SHALL run an FSM with states IDLE, WAIT, OKAY, ERR1, ERR2.
REQ-010 SHALL leave IDLE on an accepted transfer:
- error -> ERR1.
- WaitStates=0 -> OKAY.
- else -> WAIT, with the wait counter loaded to WaitStates-1.
REQ-011 SHALL hold WAIT with HREADYOUT=0, HRESP=0, decrementing the counter each cycle; at zero it SHALL go to OKAY.
REQ-012 SHALL drive OKAY for exactly one cycle: HREADYOUT=1, HRESP=0.
- Next state is IDLE, or the next phase's first state if a new transfer is accepted in the same cycle (back-to-back).
REQ-013 SHALL drive ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1).
- ERR2 SHALL accept a new address phase like OKAY.
REQ-014 SHALL present read data on HRDATA in the HREADYOUT=1 cycle of an OKAY read; the full word is driven, other lanes are don't-care to the master.
REQ-015 SHALL write HWDATA at the clock edge ending an OKAY write data phase, only into the byte lanes selected by HSIZE and HADDR[log2(DataWidth/8)-1:0].
REQ-016 SHALL return the new data on a read of the same word immediately following a write (no stale data).
REQ-017 SHALL never modify memory on ERROR transfers.
REQ-018 SHALL hold HRDATA at its last value outside OKAY read cycles.

Reset
REQ-019 SHALL, while HRESET=1, force state IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-020 SHALL abort any in-flight transfer when HRESET is asserted mid-phase, with no memory write.
REQ-021 SHALL NOT reset memory contents.

Structure
REQ-022 SHALL take HTRANS/HSIZE typedefs and constants and the FSM state enum from a shared package ahb_sram_pkg.
REQ-023 SHALL generate byte-lane enables in one sub-module, ahb_sram_lane_mask (inputs HSIZE and address low bits, output a DataWidth/8 mask).

Verification
REQ-024 SHALL cover: WaitStates=0, write word 0xDEADBEEF @0x10, then read @0x10 -> HREADYOUT never low, read returns 0xDEADBEEF.
REQ-025 SHALL cover: WaitStates=3, read @0x0 -> HREADYOUT low exactly 3 cycles, then high with data.
REQ-026 SHALL cover: DataWidth=32, fill 0x11223344 @0x20, then byte write 0xAA @0x22 -> read @0x20 returns 0x11AA3344.
REQ-027 SHALL cover: Depth=1024, DataWidth=32, read @0x1000, then NONSEQ @0x4 -> ERR1/ERR2 two-cycle ERROR, then @0x4 completes OKAY.
REQ-028 SHALL cover: WaitStates=2, write @0x8, HRESET pulsed in the second wait cycle -> outputs reach reset values asynchronously, word @0x8 unchanged.
REQ-029 SHALL cover: halfword read @0x1 -> ERROR response, memory untouched.
